mem_wb_pipe_reg: RTL

MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

---
 rtl/mem_wb_pipe_reg_if.sv | 39 +++
 rtl/mem_wb_pipe_reg.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM/WB stage bus: upstream offer/accept, downstream head presentation,
// and the status outputs seen by the hazard/forwarding unit.
interface mem_wb_pipe_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              WB_EN_IN;
    logic              MEM_R_EN_IN;
    logic [DATA_W-1:0] ALU_result_IN;
    logic [DATA_W-1:0] MEM_read_value_IN;
    logic [DEST_W-1:0] Dest_IN;

    logic              out_valid;
    logic              out_ready;
    logic              WB_EN;
    logic              MEM_R_EN;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] MEM_read_value;
    logic [DEST_W-1:0] Dest;

    logic              fwd_en;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, WB_EN_IN, MEM_R_EN_IN, ALU_result_IN, MEM_read_value_IN, Dest_IN,
        output out_ready,
        input  in_ready, out_valid, WB_EN, MEM_R_EN, ALU_result, MEM_read_value, Dest,
        input  fwd_en, occupancy
    );

    modport slave (
        input  in_valid, WB_EN_IN, MEM_R_EN_IN, ALU_result_IN, MEM_read_value_IN, Dest_IN,
        input  out_ready,
        output in_ready, out_valid, WB_EN, MEM_R_EN, ALU_result, MEM_read_value, Dest,
        output fwd_en, occupancy
    );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, freeze, flush and an
// optional second (skid) entry that removes the out_ready -> in_ready path.
module mem_wb_pipe_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEST_W  = 4,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    mem_wb_pipe_reg_if.slave    bus
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_read_value;
        logic [DEST_W-1:0] dest;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_ready;
    logic   out_valid;
    logic   accept;
    logic   consume;

    assign in_entry.wb_en          = bus.WB_EN_IN;
    assign in_entry.mem_r_en       = bus.MEM_R_EN_IN;
    assign in_entry.alu_result     = bus.ALU_result_IN;
    assign in_entry.mem_read_value = bus.MEM_read_value_IN;
    assign in_entry.dest           = bus.Dest_IN;

    // With the skid entry, in_ready depends only on registered state.
    assign in_ready  = ~freeze & (SKID_EN ? (state_q != FULL)
                                          : ((state_q == EMPTY) | bus.out_ready));
    assign out_valid = ~freeze & (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign consume   = out_valid & bus.out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d         = EMPTY;
            head_d.wb_en    = 1'b0;
            head_d.mem_r_en = 1'b0;
            skid_d.wb_en    = 1'b0;
            skid_d.mem_r_en = 1'b0;
        end else begin
            // Freeze needs no branch: it already forces accept and consume low.
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= EMPTY;
            // NOTE: the entry registers are reset because their zeroed fields are visible on the outputs.
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.WB_EN          = out_valid & head_q.wb_en;
    assign bus.MEM_R_EN       = out_valid & head_q.mem_r_en;
    assign bus.fwd_en         = out_valid & head_q.wb_en;
    assign bus.ALU_result     = head_q.alu_result;
    assign bus.MEM_read_value = head_q.mem_read_value;
    assign bus.Dest           = head_q.dest;
    assign bus.occupancy      = state_q;

endmodule
